parity_checker: RTL and testbench

PARITY_CHECKER -- requirements
Module: parity_checker

---
 rtl/parity_checker.sv | 140 ++++++++++++++
 tb/tb_parity_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_checker.sv
// ---------------------------------------------------------------------------
// parity_checker
//
// Serial frame receiver with parity checking. A frame is DATA_W data bits
// sent LSB first, followed by one parity bit. Each bit arrives through a
// valid/ready handshake. The assembled word and its parity verdict are
// presented through a second valid/ready handshake.
//
// Parameters
//   DATA_W      data bits per frame, 1..32
//   PARITY_ODD  0 = even parity (parity bit = XOR of data bits)
//               1 = odd parity  (parity bit = NOT XOR of data bits)
//
// Ports
//   i_clk          sole clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_bit          serial bit, taken when i_bit_valid & o_bit_ready
//   i_bit_valid    i_bit carries a bit this cycle
//   o_bit_ready    checker will take a bit this cycle
//   o_data         received word, held while o_frame_valid is 1
//   o_par_err      parity mismatch for the frame on o_data
//   o_frame_valid  a completed frame is presented
//   i_frame_ready  consumer takes the frame this cycle
//   o_err_cnt      saturating count of handshaken frames with a parity
//                  error (present only when PARITY_ERR_CNT_EN is defined)
//
// Optional feature macro: PARITY_ERR_CNT_EN
// ---------------------------------------------------------------------------
module parity_checker #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit,
  input  logic              i_bit_valid,
  output logic              o_bit_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_par_err,
  output logic              o_frame_valid,
  input  logic              i_frame_ready
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]        o_err_cnt
`endif
);

  // A one-bit frame still needs a one-bit counter so the vectors stay legal.
  localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic            ODD_BIT  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    ST_DATA,
    ST_PARITY,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             run_xor;
  logic             bit_accept;
  logic             frame_accept;

  assign bit_accept   = i_bit_valid & o_bit_ready;
  assign frame_accept = o_frame_valid & i_frame_ready;

  // Frame FSM. o_bit_ready and o_frame_valid are registered and always set
  // together with the state they belong to. o_bit_ready is 0 during reset
  // and is raised on the first clock in ST_DATA after reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ST_DATA;
      bit_cnt       <= '0;
      run_xor       <= 1'b0;
      o_data        <= '0;
      o_par_err     <= 1'b0;
      o_frame_valid <= 1'b0;
      o_bit_ready   <= 1'b0;
    end else begin
      case (state)
        ST_DATA: begin
          o_bit_ready <= 1'b1;
          if (bit_accept) begin
            o_data[bit_cnt] <= i_bit;
            run_xor         <= run_xor ^ i_bit;
            if (bit_cnt == LAST_IDX) begin
              bit_cnt <= '0;
              state   <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (bit_accept) begin
            o_par_err     <= run_xor ^ i_bit ^ ODD_BIT;
            o_frame_valid <= 1'b1;
            o_bit_ready   <= 1'b0;
            state         <= ST_DONE;
          end
        end

        // The frame is held here; bits offered meanwhile are not taken
        // because o_bit_ready is low.
        ST_DONE: begin
          if (frame_accept) begin
            o_frame_valid <= 1'b0;
            o_bit_ready   <= 1'b1;
            bit_cnt       <= '0;
            run_xor       <= 1'b0;
            state         <= ST_DATA;
          end
        end

        default: begin
          o_frame_valid <= 1'b0;
          o_bit_ready   <= 1'b0;
          bit_cnt       <= '0;
          run_xor       <= 1'b0;
          state         <= ST_DATA;
        end
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Counts frames that were actually handed over with a parity error and
  // sticks at 255 instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err_cnt <= 8'd0;
    end else if (frame_accept && o_par_err && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_checker
//
// Drives two parity_checker instances, one with even parity (dut0) and one
// with odd parity (dut1). Frames are sent with directed data and
// hand-computed parity verdicts. The expected frame goes into a per-DUT
// queue when its parity bit is issued, and a monitor per DUT pops and
// compares it whenever that DUT hands over a frame.
// ---------------------------------------------------------------------------
module tb_parity_checker;

  typedef struct packed {
    logic [7:0] data;
    logic       par_err;
  } exp_t;

  logic       clk;
  logic       rst_n;

  logic       bit0, val0, rdy0, err0, fv0, fr0;
  logic [7:0] data0;
  logic       bit1, val1, rdy1, err1, fv1, fr1;
  logic [7:0] data1;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  parity_checker #(.DATA_W(8), .PARITY_ODD(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit0), .i_bit_valid(val0),
    .o_bit_ready(rdy0), .o_data(data0), .o_par_err(err0),
    .o_frame_valid(fv0), .i_frame_ready(fr0)
`ifdef PARITY_ERR_CNT_EN
    , .o_err_cnt(cnt0)
`endif
  );

  parity_checker #(.DATA_W(8), .PARITY_ODD(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit(bit1), .i_bit_valid(val1),
    .o_bit_ready(rdy1), .o_data(data1), .o_par_err(err1),
    .o_frame_valid(fv1), .i_frame_ready(fr1)
`ifdef PARITY_ERR_CNT_EN
    , .o_err_cnt(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offers one bit and holds it until the DUT takes it.
  task automatic send_bit(input int d, input logic b);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    if (d == 0) begin bit0 = b; val0 = 1'b1; end
    else        begin bit1 = b; val1 = 1'b1; end
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = (d == 0) ? rdy0 : rdy1;
      @(posedge clk);
      #1;
      guard++;
    end
    if (d == 0) val0 = 1'b0;
    else        val1 = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL bit_accept_timeout dut%0d: got no ready, expected ready", d);
    end
  endtask

  // Sends a whole frame; the expected result is queued just before the
  // parity bit goes out.
  task automatic applyStimulus(input int d, input logic [7:0] data,
                               input logic par, input logic exp_err,
                               input int gap);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      send_bit(d, data[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
    e.data    = data;
    e.par_err = exp_err;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    send_bit(d, par);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (fv0 && fr0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut0_unexpected_frame: got data %0h, expected none", data0);
      end else begin
        e = q0.pop_front();
        checkOutput("dut0_data", 32'(data0), 32'(e.data));
        checkOutput("dut0_par_err", 32'(err0), 32'(e.par_err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (fv1 && fr1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut1_unexpected_frame: got data %0h, expected none", data1);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1_data", 32'(data1), 32'(e.data));
        checkOutput("dut1_par_err", 32'(err1), 32'(e.par_err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bit0 = 1'b0; val0 = 1'b0; fr0 = 1'b1;
    bit1 = 1'b0; val1 = 1'b0; fr1 = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_data", 32'(data0), 32'h0);
    checkOutput("rst_par_err", 32'(err0), 32'h0);
    checkOutput("rst_frame_valid", 32'(fv0), 32'h0);
    checkOutput("rst_bit_ready", 32'(rdy0), 32'h0);
    checkOutput("rst_bit_ready_dut1", 32'(rdy1), 32'h0);
`ifdef PARITY_ERR_CNT_EN
    checkOutput("rst_err_cnt", 32'(cnt0), 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_bit_ready", 32'(rdy0), 32'h1);
    checkOutput("post_rst_bit_ready_dut1", 32'(rdy1), 32'h1);
    @(posedge clk); #1;

    // Even parity: A5 has four ones, 07 has three ones
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 0);
    applyStimulus(0, 8'h07, 1'b0, 1'b1, 0);
    repeat (3) begin @(posedge clk); #1; end
`ifdef PARITY_ERR_CNT_EN
    checkOutput("err_cnt_after_07", 32'(cnt0), 32'h1);
`endif

    // Odd parity on 00
    applyStimulus(1, 8'h00, 1'b1, 1'b0, 0);
    applyStimulus(1, 8'h00, 1'b0, 1'b1, 0);

    // Backpressure: frame held, offered bits ignored
    fr0 = 1'b0;
    applyStimulus(0, 8'h5A, 1'b0, 1'b0, 0);
    bit0 = 1'b1;
    val0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_bit_ready", 32'(rdy0), 32'h0);
      checkOutput("bp_data_stable", 32'(data0), 32'h5A);
      checkOutput("bp_frame_valid", 32'(fv0), 32'h1);
      checkOutput("bp_par_err_stable", 32'(err0), 32'h0);
      @(posedge clk); #1;
    end
    val0 = 1'b0;
    fr0  = 1'b1;
    applyStimulus(0, 8'hC3, 1'b1, 1'b1, 0);
    repeat (3) begin @(posedge clk); #1; end

    // Gapped partial frame aborted by reset
    for (int k = 0; k < 4; k++) begin
      send_bit(0, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_frame_valid", 32'(fv0), 32'h0);
    checkOutput("midrst_bit_ready", 32'(rdy0), 32'h0);
    checkOutput("midrst_data", 32'(data0), 32'h0);
`ifdef PARITY_ERR_CNT_EN
    checkOutput("midrst_err_cnt", 32'(cnt0), 32'h0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 2);
    repeat (3) begin @(posedge clk); #1; end

`ifdef PARITY_ERR_CNT_EN
    // Saturation of the error counter
    for (int n = 0; n < 260; n++) begin
      applyStimulus(0, 8'h07, 1'b0, 1'b1, 0);
    end
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("err_cnt_saturated", 32'(cnt0), 32'd255);
`endif

    repeat (5) begin @(posedge clk); #1; end
    checkOutput("dut0_pending_frames", 32'(q0.size()), 32'h0);
    checkOutput("dut1_pending_frames", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
